// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus of ifetch_ctrl: instruction memory port, redirect input and
// the valid/ready hand-off to decode. The controller uses the master modport.
interface ifetch_ctrl_if;
    logic        fetch_en;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    modport master (
        input  fetch_en,
        input  imem_inst,
        input  redirect_valid,
        input  redirect_pc,
        input  if_ready,
        output imem_pc,
        output if_valid,
        output if_inst,
        output if_pc
    );

    modport slave (
        output fetch_en,
        output imem_inst,
        output redirect_valid,
        output redirect_pc,
        output if_ready,
        input  imem_pc,
        input  if_valid,
        input  if_inst,
        input  if_pc
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: issues word-aligned fetches to a registered
// instruction memory (one-cycle latency), tracks the single in-flight read,
// buffers returned words in a small FIFO and hands them to decode. Redirects
// flush everything and restart fetch at the new target.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    ifetch_ctrl_if.master bus
);

    localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
    localparam logic [CntW:0]   DepthOcc  = (CntW + 1)'(BUF_DEPTH);
    localparam logic [CntW-1:0] DepthCnt  = CntW'(BUF_DEPTH);
    localparam logic [PtrW-1:0] LastSlot  = PtrW'(BUF_DEPTH - 1);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic            inflight_valid_q, inflight_valid_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic [31:0]     buf_pc_q   [BUF_DEPTH];
    logic [31:0]     buf_inst_q [BUF_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic            buf_nonempty;
    logic            pop;
    logic            push;
    logic            issue;
    logic [CntW:0]   occupancy;
    logic            unused_redirect_lo;

    // Low target bits are forced to zero, so they never reach any logic.
    assign unused_redirect_lo = ^bus.redirect_pc[1:0];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == LastSlot) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Decode-side outputs and the push/pop/issue decisions for this cycle.
    always_comb begin
        buf_nonempty = (count_q != '0);
        // A redirect masks valid so that no stale instruction transfers.
        bus.if_valid = buf_nonempty & ~bus.redirect_valid;
        bus.if_inst  = buf_nonempty ? buf_inst_q[rd_ptr_q] : 32'h0;
        bus.if_pc    = buf_nonempty ? buf_pc_q[rd_ptr_q] : 32'h0;
        bus.imem_pc  = fetch_pc_q;

        pop  = bus.if_valid & bus.if_ready;
        push = inflight_valid_q & ~bus.redirect_valid;
        // Reserve a slot for every outstanding read so the FIFO never overflows.
        occupancy = {1'b0, count_q} + (CntW + 1)'(inflight_valid_q) - (CntW + 1)'(pop);
        issue     = bus.fetch_en & ~bus.redirect_valid & (occupancy < DepthOcc);
    end

    // Next-state for fetch PC, in-flight tracking and FIFO pointers.
    always_comb begin
        fetch_pc_d       = fetch_pc_q;
        inflight_valid_d = inflight_valid_q;
        inflight_pc_d    = inflight_pc_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        count_d          = count_q;

        if (bus.redirect_valid) begin
            fetch_pc_d       = {bus.redirect_pc[31:2], 2'b00};
            inflight_valid_d = 1'b0;
            rd_ptr_d         = '0;
            wr_ptr_d         = '0;
            count_d          = '0;
        end else begin
            inflight_valid_d = issue;
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q       <= RESET_PC;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= 32'h0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
        end
    end

    // FIFO payload; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]   <= inflight_pc_q;
            buf_inst_q[wr_ptr_q] <= bus.imem_inst;
        end
    end

`ifndef SYNTHESIS
    // The issue rule must keep a push from landing in a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && count_q == DepthCnt))
            else $error("ifetch_ctrl: instruction FIFO overflow");
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed stimulus per cycle, expected PC stream kept
// in a queue, and a negedge monitor that checks every decode transfer.
module tb_ifetch_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [31:0] exp_q [$];

    ifetch_ctrl_if bus ();

    ifetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'h1000_0000 + {2'b00, pc[31:2]};
    endfunction

    // Registered instruction memory; reads 0 while in reset.
    always @(posedge clk) begin
        bus.imem_inst <= rst ? 32'h0 : mem_word(bus.imem_pc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted instruction must match the next expected PC.
    always @(negedge clk) begin
        if (bus.if_valid === 1'b1 && bus.if_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_xfer: got pc %h, expected no transfer", bus.if_pc);
            end else begin
                logic [31:0] epc;
                epc = exp_q.pop_front();
                chk("xfer_pc", bus.if_pc, epc);
                chk("xfer_inst", bus.if_inst, mem_word(epc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle-exact checks; c counts cycles from the first one after reset release.
    task automatic check_cycle(input int c);
        if (c == 0 || c == 1) chk("first_valid_low", 32'(bus.if_valid), 32'd0);
        if (c == 2) chk("first_valid_c2", 32'(bus.if_valid), 32'd1);
        if (c >= 10 && c <= 14) begin
            chk("bp_valid", 32'(bus.if_valid), 32'd1);
            chk("bp_head_pc", bus.if_pc, 32'd32);
            chk("bp_head_inst", bus.if_inst, 32'h1000_0008);
        end
        if (c == 14) chk("bp_issue_stop", bus.imem_pc, 32'd40);
        if (c >= 20 && c <= 22) chk("redir_valid_low", 32'(bus.if_valid), 32'd0);
        if (c == 21) chk("redir_target", bus.imem_pc, 32'h40);
        if (c == 23) chk("redir_valid_r3", 32'(bus.if_valid), 32'd1);
        if (c >= 30 && c <= 33) chk("fen_valid_low", 32'(bus.if_valid), 32'd0);
        if (c == 30) chk("fen_pc_hold", bus.imem_pc, 32'h5C);
        if (c == 39) begin
            chk("rstp_valid", 32'(bus.if_valid), 32'd0);
            chk("rstp_inst", bus.if_inst, 32'd0);
            chk("rstp_pc", bus.if_pc, 32'd0);
            chk("rstp_imem_pc", bus.imem_pc, 32'd0);
        end
        if (c == 40) chk("rstp_valid_c1", 32'(bus.if_valid), 32'd0);
        if (c == 41) chk("rstp_valid_c2", 32'(bus.if_valid), 32'd1);
        if (c >= 46 && c <= 49) chk("wrap_valid_low", 32'(bus.if_valid), 32'd0);
        if (c == 48) chk("last_redirect_wins", bus.imem_pc, 32'hFFFF_FFF8);
        if (c == 50) chk("wrap_valid", 32'(bus.if_valid), 32'd1);
    endtask

    initial begin
        rst                = 1'b1;
        bus.fetch_en       = 1'b1;
        bus.if_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_inst      = 32'h0;
        tick();
        tick();
        @(negedge clk);
        chk("reset_valid", 32'(bus.if_valid), 32'd0);
        chk("reset_inst", bus.if_inst, 32'd0);
        chk("reset_pc", bus.if_pc, 32'd0);
        chk("reset_imem_pc", bus.imem_pc, 32'd0);

        // Sequential stream 0..48; PC 52 is dropped by the redirect in cycle 20.
        for (int i = 0; i < 13; i++) exp_q.push_back(32'(4 * i));
        tick();

        for (int c = 0; c < 58; c++) begin
            rst                = (c == 38);
            bus.fetch_en       = !(c >= 28 && c <= 31);
            bus.if_ready       = !((c >= 10 && c <= 14) || c == 38 || c >= 54);
            bus.redirect_valid = (c == 20 || c == 46 || c == 47);
            bus.redirect_pc    = (c == 20) ? 32'h0000_0042 :
                                 (c == 46) ? 32'h0000_0100 : 32'hFFFF_FFFB;
            if (c == 20 || c == 39 || c == 46) begin
                chk("drained", 32'(exp_q.size()), 32'd0);
            end
            if (c == 20) begin
                for (int i = 0; i < 11; i++) exp_q.push_back(32'h40 + 32'(4 * i));
            end
            if (c == 39) begin
                for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
            end
            if (c == 46) begin
                exp_q.push_back(32'hFFFF_FFF8);
                exp_q.push_back(32'hFFFF_FFFC);
                exp_q.push_back(32'h0000_0000);
                exp_q.push_back(32'h0000_0004);
            end
            @(negedge clk);
            check_cycle(c);
            tick();
        end

        chk("final_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
